// File: rtl/fp_addsub_pipe_if.sv
// Handshake/data bundle for fp_addsub_pipe: operand side (a, b, op_add, in_tag,
// in_valid/in_ready) and result side (result, out_tag, out_valid/out_ready).
interface fp_addsub_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             op_add;
    logic [TAG_W-1:0] in_tag;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     result;
    logic [TAG_W-1:0] out_tag;
    logic             out_valid;
    logic             out_ready;

    // Producer/consumer side (scheduler + packer)
    modport master (
        output a, b, op_add, in_tag, in_valid, out_ready,
        input  in_ready, result, out_tag, out_valid
    );

    // Arithmetic block side
    modport slave (
        input  a, b, op_add, in_tag, in_valid, out_ready,
        output in_ready, result, out_tag, out_valid
    );
endinterface

// File: rtl/fp_addsub_pipe.sv
// Five-stage IEEE-754-style add/subtract with RNE rounding, flush-to-zero of
// subnormals, inf/NaN handling, tag passthrough and whole-pipe backpressure.
// Stages: S1 unpack, S2 swap/align, S3 add/sub, S4 normalise, S5 round/pack.
// Optional macro FP_ADDSUB_FLAGS_EN adds flags[3:0] = {invalid, overflow,
// underflow, inexact}, aligned with result.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    fp_addsub_pipe_if.slave bus
`ifdef FP_ADDSUB_FLAGS_EN
    ,
    output logic [3:0]      flags
`endif
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int MW = MAN_W + 4;  // hidden + fraction + G/R/S
    localparam logic [EXP_W-1:0] EMAX = '1;
    localparam logic [W-1:0]     QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic             sa, sb;          // sb is already the effective sign
        logic [EXP_W-1:0] ea, eb;
        logic [MAN_W-1:0] fa, fb;
        logic             za, zb, ia, ib, na, nb;
        logic [TAG_W-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic             sl, ss;
        logic [EXP_W-1:0] el;
        logic [MW-1:0]    ml, ms;
        logic             sp;
        logic [W-1:0]     spv;
`ifdef FP_ADDSUB_FLAGS_EN
        logic             inv;
`endif
        logic [TAG_W-1:0] tag;
    } s2_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] el;
        logic [MW:0]      sum;
        logic             sp;
        logic [W-1:0]     spv;
`ifdef FP_ADDSUB_FLAGS_EN
        logic             inv;
`endif
        logic [TAG_W-1:0] tag;
    } s3_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W:0]   ex;
        logic [MW-1:0]    m;
        logic             zero;
        logic             sp;
        logic [W-1:0]     spv;
`ifdef FP_ADDSUB_FLAGS_EN
        logic             inv;
        logic             uf;
`endif
        logic [TAG_W-1:0] tag;
    } s4_t;

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;
    s3_t s3_d, s3_q;
    s4_t s4_d, s4_q;

    logic [5:1]       vld_q;
    logic             stall, adv;
    logic [W-1:0]     result_d, result_q;
    logic [TAG_W-1:0] out_tag_q;

    // S2 working values
    logic [MAN_W:0]   ma, mb, m_s;
    logic [EXP_W-1:0] d;
    logic [MW-1:0]    ext, sh;
    logic             a_big, lost;
    // S4 working values
    int               en, lzc;
    logic [MW-1:0]    m_n;
    // S5 working values
    logic             inc, ovf;
    logic [MAN_W+1:0] mr;
    logic [EXP_W+1:0] er;
    logic [MAN_W-1:0] frac;

    // The whole pipe freezes only when the output holds an unaccepted result.
    assign stall        = bus.out_valid && !bus.out_ready;
    assign adv          = !stall;
    assign bus.in_ready = adv;
    assign bus.out_valid = vld_q[5];
    assign bus.result    = result_q;
    assign bus.out_tag   = out_tag_q;

    // Stage valid bits; bubbles travel as zeros and are not squeezed out.
    always_ff @(posedge clk) begin
        if (reset)    vld_q <= '0;
        else if (adv) vld_q <= {vld_q[4:1], bus.in_valid};
    end

    // S1: split fields, classify, fold op_add into B's sign, flush subnormals.
    always_comb begin
        s1_d     = '0;
        s1_d.sa  = bus.a[W-1];
        s1_d.sb  = bus.b[W-1] ^ ~bus.op_add;
        s1_d.ea  = bus.a[W-2 -: EXP_W];
        s1_d.eb  = bus.b[W-2 -: EXP_W];
        s1_d.za  = (s1_d.ea == '0);
        s1_d.zb  = (s1_d.eb == '0);
        s1_d.fa  = s1_d.za ? '0 : bus.a[MAN_W-1:0];
        s1_d.fb  = s1_d.zb ? '0 : bus.b[MAN_W-1:0];
        s1_d.ia  = (s1_d.ea == EMAX) && (bus.a[MAN_W-1:0] == '0);
        s1_d.ib  = (s1_d.eb == EMAX) && (bus.b[MAN_W-1:0] == '0);
        s1_d.na  = (s1_d.ea == EMAX) && (bus.a[MAN_W-1:0] != '0);
        s1_d.nb  = (s1_d.eb == EMAX) && (bus.b[MAN_W-1:0] != '0);
        s1_d.tag = bus.in_tag;
    end

    // S2: order by magnitude (A wins ties), align smaller with sticky, resolve specials.
    always_comb begin
        s2_d     = '0;
        s2_d.tag = s1_q.tag;
        ma       = s1_q.za ? '0 : {1'b1, s1_q.fa};
        mb       = s1_q.zb ? '0 : {1'b1, s1_q.fb};
        a_big    = {s1_q.ea, ma} >= {s1_q.eb, mb};
        if (a_big) begin
            s2_d.sl = s1_q.sa;  s2_d.ss = s1_q.sb;  s2_d.el = s1_q.ea;
            s2_d.ml = {ma, 3'b000};  m_s = mb;  d = s1_q.ea - s1_q.eb;
        end else begin
            s2_d.sl = s1_q.sb;  s2_d.ss = s1_q.sa;  s2_d.el = s1_q.eb;
            s2_d.ml = {mb, 3'b000};  m_s = ma;  d = s1_q.eb - s1_q.ea;
        end
        ext = {m_s, 3'b000};
        if (32'(d) >= MAN_W + 3) begin
            sh   = '0;
            lost = |m_s;
        end else begin
            sh   = ext >> d;
            lost = |(ext & ~({MW{1'b1}} << d));
        end
        s2_d.ms = {sh[MW-1:1], sh[0] | lost};

        s2_d.sp  = 1'b1;
        s2_d.spv = '0;
        if (s1_q.na || s1_q.nb || (s1_q.ia && s1_q.ib && (s1_q.sa != s1_q.sb))) begin
            s2_d.spv = QNAN;
`ifdef FP_ADDSUB_FLAGS_EN
            s2_d.inv = 1'b1;
`endif
        end else if (s1_q.ia)               s2_d.spv = {s1_q.sa, EMAX, {MAN_W{1'b0}}};
        else if (s1_q.ib)                   s2_d.spv = {s1_q.sb, EMAX, {MAN_W{1'b0}}};
        else if (s1_q.za && s1_q.zb)        s2_d.spv = {s1_q.sa & s1_q.sb, {(W-1){1'b0}}};
        else if (s1_q.zb)                   s2_d.spv = {s1_q.sa, s1_q.ea, s1_q.fa};
        else if (s1_q.za)                   s2_d.spv = {s1_q.sb, s1_q.eb, s1_q.fb};
        else                                s2_d.sp  = 1'b0;
    end

    // S3: magnitude add or subtract; the larger operand sets the sign.
    always_comb begin
        s3_d      = '0;
        s3_d.sign = s2_q.sl;
        s3_d.el   = s2_q.el;
        s3_d.sum  = (s2_q.sl != s2_q.ss) ? ({1'b0, s2_q.ml} - {1'b0, s2_q.ms})
                                         : ({1'b0, s2_q.ml} + {1'b0, s2_q.ms});
        s3_d.sp   = s2_q.sp;
        s3_d.spv  = s2_q.spv;
`ifdef FP_ADDSUB_FLAGS_EN
        s3_d.inv  = s2_q.inv;
`endif
        s3_d.tag  = s2_q.tag;
    end

    // S4: normalise (carry right-shift or leading-zero left-shift), flush underflow.
    always_comb begin
        s4_d      = '0;
        s4_d.sign = s3_q.sign;
        s4_d.sp   = s3_q.sp;
        s4_d.spv  = s3_q.spv;
`ifdef FP_ADDSUB_FLAGS_EN
        s4_d.inv  = s3_q.inv;
`endif
        s4_d.tag  = s3_q.tag;
        lzc = MW;
        for (int i = 0; i < MW; i++) begin
            if (s3_q.sum[i]) lzc = MW - 1 - i;
        end
        en  = int'({1'b0, s3_q.el});
        m_n = '0;
        if (s3_q.sum == '0) begin
            s4_d.zero = 1'b1;
            s4_d.sign = 1'b0;
        end else begin
            if (s3_q.sum[MW]) begin
                m_n = {s3_q.sum[MW:2], s3_q.sum[1] | s3_q.sum[0]};
                en  = en + 1;
            end else begin
                m_n = s3_q.sum[MW-1:0] << lzc;
                en  = en - lzc;
            end
            if (en <= 0) begin
                s4_d.zero = 1'b1;
`ifdef FP_ADDSUB_FLAGS_EN
                s4_d.uf   = 1'b1;
`endif
            end else begin
                s4_d.m  = m_n;
                s4_d.ex = en[EXP_W:0];
            end
        end
    end

    // S5: round to nearest even, then pack with overflow to inf and special override.
    always_comb begin
        inc  = s4_q.m[2] & (s4_q.m[1] | s4_q.m[0] | s4_q.m[3]);
        mr   = {1'b0, s4_q.m[MW-1:3]} + {{(MAN_W+1){1'b0}}, inc};
        er   = {1'b0, s4_q.ex} + {{(EXP_W+1){1'b0}}, mr[MAN_W+1]};
        ovf  = er >= {2'b00, EMAX};
        frac = mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0];
        if (s4_q.sp)        result_d = s4_q.spv;
        else if (s4_q.zero) result_d = {s4_q.sign, {(W-1){1'b0}}};
        else if (ovf)       result_d = {s4_q.sign, EMAX, {MAN_W{1'b0}}};
        else                result_d = {s4_q.sign, er[EXP_W-1:0], frac};
    end

    // Stage data registers; all hold while the output is stalled.
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
            s4_q <= s4_d;
        end
    end

    // Output stage registers; only loaded by real operations.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q  <= '0;
            out_tag_q <= '0;
        end else if (adv && vld_q[4]) begin
            result_q  <= result_d;
            out_tag_q <= s4_q.tag;
        end
    end

`ifdef FP_ADDSUB_FLAGS_EN
    logic [3:0] flags_d, flags_q;
    logic       f_ovf, f_uf;

    // Exception flags: only arithmetic (non-special) results can overflow/underflow.
    always_comb begin
        f_ovf   = !s4_q.sp && !s4_q.zero && ovf;
        f_uf    = !s4_q.sp && s4_q.uf;
        flags_d = {s4_q.sp & s4_q.inv, f_ovf, f_uf,
                   !s4_q.sp && (f_ovf || f_uf || (!s4_q.zero && (|s4_q.m[2:0])))};
    end

    // Flags register, aligned with result.
    always_ff @(posedge clk) begin
        if (reset)                  flags_q <= '0;
        else if (adv && vld_q[4])   flags_q <= flags_d;
    end

    assign flags = flags_q;
`endif
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe (FP32 defaults): vector table for the
// arithmetic and special cases, plus backpressure and mid-flight reset sequences.
module tb_fp_addsub_pipe;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int TAG_W = 4;
    localparam int NV    = 20;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fp_addsub_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) bus ();
`ifdef FP_ADDSUB_FLAGS_EN
    logic [3:0] flags;
`endif

    fp_addsub_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef FP_ADDSUB_FLAGS_EN
        ,
        .flags (flags)
`endif
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] res;
        logic [3:0]  fl;   // {invalid, overflow, underflow, inexact}
    } vec_t;

    vec_t vecs[NV];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string what, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%h want=%h", what, idx, act, exp);
        end
    endtask

    // One isolated operation; pipe is empty and out_ready is high.
    task automatic run_vec(input int i);
        int lat;
        bus.a        = vecs[i].a;
        bus.b        = vecs[i].b;
        bus.op_add   = vecs[i].op;
        bus.in_tag   = 4'(i);
        bus.in_valid = 1'b1;
        check("in_ready", i, 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", i, lat, 5);
        check("result", i, bus.result, vecs[i].res);
        check("tag", i, 32'(bus.out_tag), 32'(i % 16));
`ifdef FP_ADDSUB_FLAGS_EN
        check("flags", i, 32'(flags), 32'(vecs[i].fl));
`endif
    endtask

    logic [31:0] bp_exp[8];
    logic [3:0]  bp_pat;
    int          idx, got, seen;
    logic        prev_stall;
    logic [31:0] prev_res;
    logic [3:0]  prev_tag;

    initial begin
        vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b1, 32'h40400000, 4'h0}; // 1+2
        vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h00000000, 4'h0}; // 1-1
        vecs[2]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'hBF800000, 4'h0}; // 1-2
        vecs[3]  = '{32'h3F800000, 32'h33800000, 1'b1, 32'h3F800000, 4'h1}; // tie, even
        vecs[4]  = '{32'h3F800001, 32'h33800000, 1'b1, 32'h3F800002, 4'h1}; // tie, odd
        vecs[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, 32'h7F800000, 4'h5}; // overflow
        vecs[6]  = '{32'h7F800000, 32'h7F800000, 1'b0, 32'h7FC00000, 4'h8}; // inf-inf
        vecs[7]  = '{32'h7FC00001, 32'h3F800000, 1'b1, 32'h7FC00000, 4'h8}; // NaN in
        vecs[8]  = '{32'h80000000, 32'h80000000, 1'b1, 32'h80000000, 4'h0}; // -0 + -0
        vecs[9]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 4'h0}; // -0 - -0
        vecs[10] = '{32'h40490FDB, 32'h00000000, 1'b1, 32'h40490FDB, 4'h0}; // x+0
        vecs[11] = '{32'h3F800000, 32'h7F800000, 1'b0, 32'hFF800000, 4'h0}; // 1-inf
        vecs[12] = '{32'h00800000, 32'h00800001, 1'b0, 32'h80000000, 4'h3}; // underflow
        vecs[13] = '{32'h3FC00000, 32'h3FC00000, 1'b1, 32'h40400000, 4'h0}; // carry path
        vecs[14] = '{32'h3FFFFFFF, 32'h33800000, 1'b1, 32'h40000000, 4'h1}; // round carry
        vecs[15] = '{32'h3F800000, 32'h33C00000, 1'b1, 32'h3F800001, 4'h1}; // above half
        vecs[16] = '{32'h3F800000, 32'h00800000, 1'b1, 32'h3F800000, 4'h1}; // far shift
        vecs[17] = '{32'h3F800000, 32'h33000000, 1'b0, 32'h3F800000, 4'h1}; // borrow tie
        vecs[18] = '{32'h00000001, 32'h00000000, 1'b1, 32'h00000000, 4'h0}; // subnormal
        vecs[19] = '{32'h00000000, 32'h40000000, 1'b0, 32'hC0000000, 4'h0}; // 0-x

        // 2^i + 1 for the backpressure stream
        bp_exp = '{32'h40000000, 32'h40400000, 32'h40A00000, 32'h41100000,
                   32'h41880000, 32'h42040000, 32'h42820000, 32'h43010000};
        bp_pat = 4'b1001;  // out_ready per cycle: 1,0,0,1,...

        reset         = 1'b1;
        bus.a         = '0;
        bus.b         = '0;
        bus.op_add    = 1'b1;
        bus.in_tag    = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 0, 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        check("rst_out_valid", 0, 32'(bus.out_valid), 32'd0);
        check("rst_result", 0, bus.result, 32'd0);
        check("rst_out_tag", 0, 32'(bus.out_tag), 32'd0);
`ifdef FP_ADDSUB_FLAGS_EN
        check("rst_flags", 0, 32'(flags), 32'd0);
`endif
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", 0, 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < NV; i++) run_vec(i);
        @(posedge clk); #1;

        // Backpressure: 8 back-to-back ops with out_ready toggling.
        idx = 0;
        got = 0;
        prev_stall = 1'b0;
        prev_res = '0;
        prev_tag = '0;
        for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
            bus.out_ready = bp_pat[cyc % 4];
            bus.in_valid  = (idx < 8);
            bus.a         = 32'h3F800000 + (32'(idx) << 23);
            bus.b         = 32'h3F800000;
            bus.op_add    = 1'b1;
            bus.in_tag    = 4'(idx);
            #1;
            check("bp_in_ready", cyc, 32'(bus.in_ready),
                  32'(!(bus.out_valid && !bus.out_ready)));
            if (prev_stall) begin
                check("bp_hold_valid", cyc, 32'(bus.out_valid), 32'd1);
                check("bp_hold_result", cyc, bus.result, prev_res);
                check("bp_hold_tag", cyc, 32'(bus.out_tag), 32'(prev_tag));
            end
            if (bus.out_valid && bus.out_ready) begin
                check("bp_result", got, bus.result, bp_exp[got]);
                check("bp_tag", got, 32'(bus.out_tag), 32'(got));
                got++;
            end
            if (bus.in_valid && bus.in_ready) idx++;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_res   = bus.result;
            prev_tag   = bus.out_tag;
            @(posedge clk); #1;
        end
        check("bp_count", 0, 32'(got), 32'd8);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        seen = 0;
        repeat (10) begin
            if (bus.out_valid) seen++;
            @(posedge clk); #1;
        end
        check("bp_extra", 0, 32'(seen), 32'd0);

        // Reset mid-flight: three ops in the pipe are dropped.
        for (int k = 0; k < 3; k++) begin
            bus.a        = vecs[k].a;
            bus.b        = vecs[k].b;
            bus.op_add   = vecs[k].op;
            bus.in_tag   = 4'(k);
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        repeat (8) begin
            if (bus.out_valid) seen++;
            @(posedge clk); #1;
        end
        check("rst_flight_out", 0, 32'(seen), 32'd0);
        run_vec(0);
        run_vec(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
